ble_adv_scheduler: RTL and testbench

Sequences BLE advertising events around the packet reader/FSK modulator datapath. Per event it walks enabled advertising channels 37→38→39, sets the channel for the synthesizer, releases the packet reader (`rdr_ready`), waits for `packetDone`, inserts an inter-frame gap, then idles for the advertising interval. It sits between the top-level control/config registers and the packet reader, which it owns through that reader's active-low run/reset input.

---
 rtl/ble_adv_scheduler_pkg.sv | 25 ++
 rtl/ble_adv_scheduler_if.sv | 35 +++
 rtl/ble_adv_chan_sel.sv | 32 +++
 rtl/ble_adv_scheduler.sv | 150 +++++++++++++++
 tb/tb_ble_adv_scheduler.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ble_adv_scheduler_pkg.sv
// ==== ble_adv_scheduler_pkg : channel codes, state encodings and widths ====
// ==== rev 1.0                                                             ====
`default_nettype none

package ble_adv_scheduler_pkg;

  localparam int BLE_MEM_ADDR_W = 12;

  localparam logic [5:0] BLE_ADV_CH37 = 6'd37;
  localparam logic [5:0] BLE_ADV_CH38 = 6'd38;
  localparam logic [5:0] BLE_ADV_CH39 = 6'd39;

  typedef enum logic [3:0] {
    BLE_ADV_ST_IDLE     = 4'd0,
    BLE_ADV_ST_START    = 4'd1,
    BLE_ADV_ST_SETTLE   = 4'd2,
    BLE_ADV_ST_TX       = 4'd3,
    BLE_ADV_ST_GAP      = 4'd4,
    BLE_ADV_ST_END      = 4'd5,
    BLE_ADV_ST_INTERVAL = 4'd6
  } ble_adv_state_e;

endpackage

`default_nettype wire

// File: rtl/ble_adv_scheduler_if.sv
// ==== ble_adv_scheduler_if : control/config and packet-reader signals ====
// ==== rev 1.0                                                        ====
`default_nettype none

interface ble_adv_scheduler_if #(
  parameter int INTERVAL_W = 24
);
  import ble_adv_scheduler_pkg::*;

  logic                      enable;
  logic [2:0]                ch_map;
  logic [INTERVAL_W-1:0]     adv_interval;
  logic [BLE_MEM_ADDR_W-1:0] pkt_size;
  logic                      packetDone;
  logic                      rdr_ready;
  logic [BLE_MEM_ADDR_W-1:0] mem_size;
  logic [5:0]                chan_idx;
  logic                      tx_en;
  logic                      busy;
  logic                      event_done;
  logic                      tx_err;

  modport master (
    output enable, ch_map, adv_interval, pkt_size, packetDone,
    input  rdr_ready, mem_size, chan_idx, tx_en, busy, event_done, tx_err
  );

  modport slave (
    input  enable, ch_map, adv_interval, pkt_size, packetDone,
    output rdr_ready, mem_size, chan_idx, tx_en, busy, event_done, tx_err
  );

endinterface

`default_nettype wire

// File: rtl/ble_adv_chan_sel.sv
// ==== ble_adv_chan_sel : next enabled advertising channel above i_cur ====
// ==== rev 1.0                                                         ====
`default_nettype none

module ble_adv_chan_sel
  import ble_adv_scheduler_pkg::*;
(
  input  wire logic [2:0] i_map,
  input  wire logic [5:0] i_cur,
  output logic      [5:0] o_next,
  output logic            o_last
);

  // o_last means no enabled channel remains above i_cur.
  always_comb begin
    o_next = i_cur;
    o_last = 1'b1;
    if (i_map[0] && (i_cur < BLE_ADV_CH37)) begin
      o_next = BLE_ADV_CH37;
      o_last = 1'b0;
    end else if (i_map[1] && (i_cur < BLE_ADV_CH38)) begin
      o_next = BLE_ADV_CH38;
      o_last = 1'b0;
    end else if (i_map[2] && (i_cur < BLE_ADV_CH39)) begin
      o_next = BLE_ADV_CH39;
      o_last = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ble_adv_scheduler.sv
// ==== ble_adv_scheduler : BLE advertising event sequencer, 37->38->39    ====
// ==== optional BLE_ADV_RANDOM_DELAY_EN adds LFSR advDelay | rev 1.0      ====
`default_nettype none

module ble_adv_scheduler
  import ble_adv_scheduler_pkg::*;
#(
  parameter logic [23:0] IFS_CYCLES    = 24'd150,
  parameter logic [7:0]  SETTLE_CYCLES = 8'd16,
  parameter logic [23:0] TX_TIMEOUT    = 24'd65535,
  parameter int          INTERVAL_W    = 24
) (
  input  wire logic        clk,
  input  wire logic        ready,
  ble_adv_scheduler_if.slave bus
);

  localparam logic [INTERVAL_W:0] c_IVL_ONE = {{INTERVAL_W{1'b0}}, 1'b1};

  ble_adv_state_e            r_state, w_nstate;
  logic [2:0]                r_map;
  logic [BLE_MEM_ADDR_W-1:0] r_mem_size;
  logic [5:0]                r_chan;
  logic [INTERVAL_W:0]       r_ivl;
  logic [23:0]               r_cnt;
  logic                      r_tx_err;

  logic [23:0]         w_cnt_inc;
  logic                w_settle_done, w_tx_timeout, w_gap_done, w_ivl_done;
  logic [2:0]          w_sel_map;
  logic [5:0]          w_sel_cur, w_next_ch;
  logic                w_last;
  logic [INTERVAL_W:0] w_ivl_load, w_ivl_load_m1;
  logic                w_rdr_ready, w_tx_en, w_event_done, w_err_set;

  assign w_cnt_inc     = r_cnt + 24'd1;
  assign w_settle_done = (w_cnt_inc >= {16'd0, SETTLE_CYCLES});
  assign w_tx_timeout  = (w_cnt_inc >= TX_TIMEOUT);
  assign w_gap_done    = (r_cnt >= IFS_CYCLES);
  assign w_ivl_done    = (r_ivl[INTERVAL_W:1] == '0);

  // In START the live map is searched from below ch37 to find the first channel.
  assign w_sel_map = (r_state == BLE_ADV_ST_START) ? bus.ch_map : r_map;
  assign w_sel_cur = (r_state == BLE_ADV_ST_START) ? 6'd36 : r_chan;

  ble_adv_chan_sel u_chan_sel (
    .i_map  (w_sel_map),
    .i_cur  (w_sel_cur),
    .o_next (w_next_ch),
    .o_last (w_last)
  );

`ifdef BLE_ADV_RANDOM_DELAY_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk or negedge ready) begin
    if (!ready) begin
      r_lfsr <= 16'hACE1;
    end else if (r_state == BLE_ADV_ST_START) begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  assign w_ivl_load = {1'b0, bus.adv_interval} + {{(INTERVAL_W-7){1'b0}}, r_lfsr[7:0]};
`else
  assign w_ivl_load = {1'b0, bus.adv_interval};
`endif

  // Counter is loaded with interval-1 so INTERVAL exits exactly one interval after START.
  assign w_ivl_load_m1 = (w_ivl_load == '0) ? '0 : (w_ivl_load - c_IVL_ONE);

  always_ff @(posedge clk or negedge ready) begin
    if (!ready) begin
      r_state <= BLE_ADV_ST_IDLE;
    end else begin
      r_state <= w_nstate;
    end
  end

  always_comb begin
    w_nstate     = r_state;
    w_rdr_ready  = 1'b0;
    w_tx_en      = 1'b0;
    w_event_done = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      BLE_ADV_ST_IDLE:     if (bus.enable) w_nstate = BLE_ADV_ST_START;
      BLE_ADV_ST_START:    w_nstate = w_last ? BLE_ADV_ST_END : BLE_ADV_ST_SETTLE;
      BLE_ADV_ST_SETTLE: begin
        w_tx_en = 1'b1;
        if (w_settle_done) w_nstate = BLE_ADV_ST_TX;
      end
      BLE_ADV_ST_TX: begin
        w_tx_en     = 1'b1;
        w_rdr_ready = 1'b1;
        if (bus.packetDone) begin
          w_nstate = BLE_ADV_ST_GAP;
        end else if (w_tx_timeout) begin
          w_nstate  = BLE_ADV_ST_GAP;
          w_err_set = 1'b1;
        end
      end
      BLE_ADV_ST_GAP:      if (w_gap_done) w_nstate = w_last ? BLE_ADV_ST_END : BLE_ADV_ST_SETTLE;
      BLE_ADV_ST_END: begin
        w_event_done = 1'b1;
        w_nstate     = BLE_ADV_ST_INTERVAL;
      end
      BLE_ADV_ST_INTERVAL: if (w_ivl_done) w_nstate = bus.enable ? BLE_ADV_ST_START : BLE_ADV_ST_IDLE;
      default:             w_nstate = BLE_ADV_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge ready) begin
    if (!ready) begin
      r_map      <= 3'b000;
      r_mem_size <= '0;
      r_chan     <= BLE_ADV_CH37;
      r_ivl      <= '0;
      r_cnt      <= '0;
      r_tx_err   <= 1'b0;
    end else begin
      r_cnt    <= (w_nstate != r_state) ? 24'd0 : w_cnt_inc;
      r_tx_err <= w_err_set;
      if (r_state == BLE_ADV_ST_START) begin
        r_map      <= bus.ch_map;
        r_mem_size <= bus.pkt_size;
        r_ivl      <= w_ivl_load_m1;
      end else if (r_ivl != '0) begin
        r_ivl <= r_ivl - c_IVL_ONE;
      end
      if ((w_nstate == BLE_ADV_ST_SETTLE) && (r_state != BLE_ADV_ST_SETTLE)) begin
        r_chan <= w_next_ch;
      end
    end
  end

  assign bus.rdr_ready  = w_rdr_ready;
  assign bus.tx_en      = w_tx_en;
  assign bus.event_done = w_event_done;
  assign bus.busy       = (r_state != BLE_ADV_ST_IDLE);
  assign bus.mem_size   = r_mem_size;
  assign bus.chan_idx   = r_chan;
  assign bus.tx_err     = r_tx_err;

endmodule

`default_nettype wire

// File: tb/tb_ble_adv_scheduler.sv
// ==== tb_ble_adv_scheduler : directed checks of the advertising sequencer ====
// ==== rev 1.0                                                            ====
`default_nettype none

module tb_ble_adv_scheduler;
  import ble_adv_scheduler_pkg::*;

  logic clk = 1'b0;
  logic ready;
  always #5 clk = ~clk;

  ble_adv_scheduler_if #(.INTERVAL_W(24)) bus ();

  ble_adv_scheduler #(
    .IFS_CYCLES    (24'd50),
    .SETTLE_CYCLES (8'd8),
    .TX_TIMEOUT    (24'd100),
    .INTERVAL_W    (24)
  ) dut (
    .clk   (clk),
    .ready (ready),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Packet reader model: asserts packetDone on the negedge pd_lat cycles after release.
  int rd_cnt  = 0;
  int pd_lat  = 30;
  bit pd_hold = 1'b0;
  always @(negedge clk) begin
    if (bus.rdr_ready === 1'b1) begin
      rd_cnt++;
      bus.packetDone = (!pd_hold && rd_cnt == pd_lat);
    end else begin
      rd_cnt = 0;
      bus.packetDone = 1'b0;
    end
  end

  int cyc = 0;
  int rise_cyc[$];
  int rise_ch[$];
  int pd_cyc[$];
  int done_cyc[$];
  int err_cyc[$];
  int ch_bad = 0;
  bit seen38 = 1'b0;
  logic prev_rdy = 1'b0;
  logic [5:0] prev_ch = 6'd0;
  logic pd_s;

  always begin
    @(posedge clk);
    pd_s = bus.packetDone;
    #1;
    cyc++;
    if (bus.rdr_ready === 1'b1 && prev_rdy !== 1'b1) begin
      rise_cyc.push_back(cyc);
      rise_ch.push_back(int'(bus.chan_idx));
    end
    if (prev_rdy === 1'b1 && pd_s === 1'b1) pd_cyc.push_back(cyc);
    if (bus.event_done === 1'b1) done_cyc.push_back(cyc);
    if (bus.tx_err === 1'b1) err_cyc.push_back(cyc);
    if (bus.rdr_ready === 1'b1 && prev_rdy === 1'b1 && bus.chan_idx !== prev_ch) ch_bad++;
    if (bus.chan_idx === 6'd38) seen38 = 1'b1;
    prev_rdy = bus.rdr_ready;
    prev_ch  = bus.chan_idx;
  end

  task automatic clear_log();
    rise_cyc.delete(); rise_ch.delete(); pd_cyc.delete();
    done_cyc.delete(); err_cyc.delete();
    ch_bad = 0; seen38 = 1'b0;
  endtask

  task automatic wait_rises(input int k, input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (rise_cyc.size() >= k) break;
      @(posedge clk); #2;
    end
    ok = (rise_cyc.size() >= k);
  endtask

  task automatic wait_dones(input int k, input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (done_cyc.size() >= k) break;
      @(posedge clk); #2;
    end
    ok = (done_cyc.size() >= k);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (bus.busy === 1'b0) break;
      @(posedge clk); #2;
    end
    ok = (bus.busy === 1'b0);
  endtask

  task automatic test_reset();
    ready = 1'b1;
    #1 ready = 1'b0;
    #11;
    n_tests++; if (bus.rdr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rdr_ready got=%b exp=0", bus.rdr_ready); end
    n_tests++; if (bus.mem_size !== '0) begin n_fail++; $display("FAIL reset_mem_size got=%0d exp=0", bus.mem_size); end
    n_tests++; if (bus.chan_idx !== 6'd37) begin n_fail++; $display("FAIL reset_chan_idx got=%0d exp=37", bus.chan_idx); end
    n_tests++; if ({bus.tx_en, bus.busy, bus.event_done, bus.tx_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=0000", {bus.tx_en, bus.busy, bus.event_done, bus.tx_err});
    end
    @(negedge clk) ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_enable_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_full_map();
    bit ok;
    clear_log();
    bus.ch_map = 3'b111; bus.adv_interval = 24'd2000; bus.pkt_size = 12'd5;
    pd_lat = 30; pd_hold = 1'b0; bus.enable = 1'b1;
    wait_rises(1, 100, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL full_first_rise got=timeout exp=rise"); end
    n_tests++; if ({bus.tx_en, bus.busy} !== 2'b11) begin n_fail++; $display("FAIL full_tx_en_busy got=%b exp=11", {bus.tx_en, bus.busy}); end
    wait_rises(2, 200, ok);
    n_tests++; if (bus.mem_size !== 12'd5) begin n_fail++; $display("FAIL full_mem_size got=%0d exp=5", bus.mem_size); end
    bus.pkt_size = 12'd9;
    wait_rises(4, 3000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL full_second_event got=timeout exp=rise"); end
    n_tests++; if (bus.mem_size !== 12'd9) begin n_fail++; $display("FAIL full_mem_size_relatch got=%0d exp=9", bus.mem_size); end
    bus.enable = 1'b0;
    wait_idle(5000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL full_idle got=busy exp=idle"); end
    n_tests++; if (rise_cyc.size() != 6) begin n_fail++; $display("FAIL full_rise_count got=%0d exp=6", rise_cyc.size()); end
    n_tests++; if (rise_ch[0] != 37 || rise_ch[1] != 38 || rise_ch[2] != 39) begin
      n_fail++; $display("FAIL full_chan_seq got=%0d,%0d,%0d exp=37,38,39", rise_ch[0], rise_ch[1], rise_ch[2]);
    end
    n_tests++; if (rise_cyc[1] - pd_cyc[0] != 59) begin n_fail++; $display("FAIL full_spacing_1 got=%0d exp=59", rise_cyc[1] - pd_cyc[0]); end
    n_tests++; if (rise_cyc[2] - pd_cyc[1] != 59) begin n_fail++; $display("FAIL full_spacing_2 got=%0d exp=59", rise_cyc[2] - pd_cyc[1]); end
    n_tests++; if (rise_cyc[1] - rise_cyc[0] != 89) begin n_fail++; $display("FAIL full_rise_period got=%0d exp=89", rise_cyc[1] - rise_cyc[0]); end
    n_tests++; if (done_cyc[0] - rise_cyc[0] != 259) begin n_fail++; $display("FAIL full_done_time got=%0d exp=259", done_cyc[0] - rise_cyc[0]); end
    n_tests++; if (rise_cyc[3] - rise_cyc[0] != 2000) begin n_fail++; $display("FAIL full_interval got=%0d exp=2000", rise_cyc[3] - rise_cyc[0]); end
    n_tests++; if (done_cyc.size() != 2) begin n_fail++; $display("FAIL full_done_count got=%0d exp=2", done_cyc.size()); end
    n_tests++; if (err_cyc.size() != 0 || ch_bad != 0) begin n_fail++; $display("FAIL full_err_chg got=%0d/%0d exp=0/0", err_cyc.size(), ch_bad); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    clear_log();
    bus.ch_map = 3'b111; bus.adv_interval = 24'd2000; bus.enable = 1'b1;
    wait_rises(2, 500, ok);
    n_tests++; if (rise_ch[1] != 38) begin n_fail++; $display("FAIL drop_ch38_tx got=%0d exp=38", rise_ch[1]); end
    bus.enable = 1'b0;
    wait_idle(4000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL drop_idle got=busy exp=idle"); end
    n_tests++; if (rise_cyc.size() != 3 || rise_ch[2] != 39) begin
      n_fail++; $display("FAIL drop_ch39_sent got=%0d rises last=%0d exp=3 rises last=39", rise_cyc.size(), rise_ch[2]);
    end
    n_tests++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL drop_done_count got=%0d exp=1", done_cyc.size()); end
    repeat (100) @(posedge clk);
    #2;
    n_tests++; if (rise_cyc.size() != 3 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL drop_stays_idle got=%0d rises busy=%b exp=3 rises busy=0", rise_cyc.size(), bus.busy);
    end
  endtask

  task automatic test_map_101();
    bit ok;
    clear_log();
    bus.ch_map = 3'b101; bus.adv_interval = 24'd400; bus.enable = 1'b1;
    wait_dones(2, 1500, ok);
    bus.enable = 1'b0;
    wait_idle(1500, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL m101_idle got=busy exp=idle"); end
    n_tests++; if (seen38) begin n_fail++; $display("FAIL m101_no_ch38 got=38 seen exp=never"); end
    n_tests++; if (rise_cyc.size() != 4 || rise_ch[0] != 37 || rise_ch[1] != 39) begin
      n_fail++; $display("FAIL m101_chans got=%0d rises %0d,%0d exp=4 rises 37,39", rise_cyc.size(), rise_ch[0], rise_ch[1]);
    end
    n_tests++; if (rise_cyc[2] - rise_cyc[0] != 400) begin n_fail++; $display("FAIL m101_interval got=%0d exp=400", rise_cyc[2] - rise_cyc[0]); end
  endtask

  task automatic test_map_000();
    bit ok;
    clear_log();
    bus.ch_map = 3'b000; bus.adv_interval = 24'd300; bus.enable = 1'b1;
    wait_dones(3, 1500, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL m000_done got=timeout exp=3 pulses"); end
    bus.enable = 1'b0;
    wait_idle(1000, ok);
    n_tests++; if (rise_cyc.size() != 0) begin n_fail++; $display("FAIL m000_no_rdr got=%0d exp=0", rise_cyc.size()); end
    n_tests++; if (done_cyc[1] - done_cyc[0] != 300 || done_cyc[2] - done_cyc[1] != 300) begin
      n_fail++; $display("FAIL m000_period got=%0d,%0d exp=300,300", done_cyc[1] - done_cyc[0], done_cyc[2] - done_cyc[1]);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_log();
    bus.ch_map = 3'b011; bus.adv_interval = 24'd600; pd_hold = 1'b1; bus.enable = 1'b1;
    wait_dones(1, 1000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL tmo_done got=timeout exp=pulse"); end
    bus.enable = 1'b0;
    wait_idle(1000, ok);
    pd_hold = 1'b0;
    n_tests++; if (err_cyc.size() != 2) begin n_fail++; $display("FAIL tmo_err_count got=%0d exp=2", err_cyc.size()); end
    n_tests++; if (err_cyc[0] - rise_cyc[0] != 100) begin n_fail++; $display("FAIL tmo_err_delay got=%0d exp=100", err_cyc[0] - rise_cyc[0]); end
    n_tests++; if (rise_cyc[1] - err_cyc[0] != 59 || rise_ch[1] != 38) begin
      n_fail++; $display("FAIL tmo_next_chan got=%0d ch%0d exp=59 ch38", rise_cyc[1] - err_cyc[0], rise_ch[1]);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_log();
    bus.ch_map = 3'b000; bus.adv_interval = 24'd0; bus.enable = 1'b1;
    wait_dones(3, 100, ok);
    bus.enable = 1'b0;
    wait_idle(100, ok);
    n_tests++; if (done_cyc.size() < 3 || done_cyc[1] - done_cyc[0] != 3 || done_cyc[2] - done_cyc[1] != 3) begin
      n_fail++; $display("FAIL b2b_period got=%0d,%0d exp=3,3", done_cyc[1] - done_cyc[0], done_cyc[2] - done_cyc[1]);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    clear_log();
    bus.ch_map = 3'b111; bus.adv_interval = 24'd1000; bus.pkt_size = 12'd7; bus.enable = 1'b1;
    wait_rises(1, 100, ok);
    repeat (5) @(posedge clk);
    #3 ready = 1'b0;
    #1;
    n_tests++; if ({bus.rdr_ready, bus.tx_en, bus.busy, bus.event_done, bus.tx_err} !== 5'b00000) begin
      n_fail++; $display("FAIL arst_flags got=%b exp=00000", {bus.rdr_ready, bus.tx_en, bus.busy, bus.event_done, bus.tx_err});
    end
    n_tests++; if (bus.chan_idx !== 6'd37 || bus.mem_size !== '0) begin
      n_fail++; $display("FAIL arst_regs got=ch%0d mem%0d exp=ch37 mem0", bus.chan_idx, bus.mem_size);
    end
    @(negedge clk) ready = 1'b1;
    clear_log();
    wait_rises(1, 50, ok);
    n_tests++; if (!ok || rise_ch[0] != 37) begin n_fail++; $display("FAIL arst_restart got=%0d rises ch%0d exp=1 rise ch37", rise_cyc.size(), rise_ch[0]); end
    bus.enable = 1'b0;
    wait_idle(2000, ok);
  endtask

  initial begin
    bus.enable = 1'b0; bus.ch_map = 3'b000; bus.adv_interval = '0; bus.pkt_size = '0;
    test_reset();
    test_full_map();
    test_enable_drop();
    test_map_101();
    test_map_000();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
